// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation codes, execute-stage FSM states and op classification.
// Used by seq_alu_exec, alu_shift_unit and the ALU decoder.
package alu_pkg;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'b0000,
        ALU_SUB  = 4'b0001,
        ALU_AND  = 4'b0010,
        ALU_OR   = 4'b0011,
        ALU_XOR  = 4'b0100,
        ALU_SLT  = 4'b0101,
        ALU_SLTU = 4'b0110,
        ALU_SLL  = 4'b0111,
        ALU_SRL  = 4'b1000,
        ALU_SRA  = 4'b1001
    } alu_ctrl_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    function automatic logic is_shift(input logic [3:0] code);
        return (code == ALU_SLL) || (code == ALU_SRL) || (code == ALU_SRA);
    endfunction

endpackage

// File: rtl/alu_shift_unit.sv
// Shift engine for seq_alu_exec: one bit per cycle by default, or a single-cycle
// barrel shifter when ALU_BARREL_SHIFT_EN is defined. 'done' marks the cycle whose 'res' is final.
module alu_shift_unit
    import alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [3:0]              op,
    input  logic [XLEN-1:0]         a,
    input  logic [$clog2(XLEN)-1:0] shamt,
    output logic                    done,
    output logic [XLEN-1:0]         res
);

    localparam int SHAMT_W = $clog2(XLEN);

`ifdef ALU_BARREL_SHIFT_EN

    // Whole shift resolved in the accept cycle.
    always_comb begin
        done = start;
        case (op)
            ALU_SLL: res = a << shamt;
            ALU_SRL: res = a >> shamt;
            ALU_SRA: res = XLEN'($signed(a) >>> shamt);
            default: res = a;
        endcase
    end

`else

    localparam logic [SHAMT_W-1:0] CNT_ONE = SHAMT_W'(1);

    logic [XLEN-1:0]    work_r;
    logic [SHAMT_W-1:0] cnt_r;
    logic [3:0]         op_r;

    function automatic logic [XLEN-1:0] shift_step(input logic [3:0] code, input logic [XLEN-1:0] v);
        case (code)
            ALU_SLL: return {v[XLEN-2:0], 1'b0};
            ALU_SRL: return {1'b0, v[XLEN-1:1]};
            ALU_SRA: return {v[XLEN-1], v[XLEN-1:1]};
            default: return v;
        endcase
    endfunction

    // Working register and remaining count; a non-zero count means a shift is in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            work_r <= {XLEN{1'b0}};
            cnt_r  <= {SHAMT_W{1'b0}};
            op_r   <= 4'b0000;
        end else if (start) begin
            work_r <= a;
            cnt_r  <= shamt;
            op_r   <= op;
        end else if (cnt_r != {SHAMT_W{1'b0}}) begin
            work_r <= shift_step(op_r, work_r);
            cnt_r  <= cnt_r - CNT_ONE;
        end else begin
            work_r <= work_r;
            cnt_r  <= cnt_r;
            op_r   <= op_r;
        end
    end

    // The last step is presented combinationally so it lands in the result register on the same edge.
    always_comb begin
        done = 1'b0;
        res  = work_r;
        if (start) begin
            done = (shamt == {SHAMT_W{1'b0}});
            res  = a;
        end else if (cnt_r == CNT_ONE) begin
            done = 1'b1;
            res  = shift_step(op_r, work_r);
        end else begin
            done = 1'b0;
            res  = work_r;
        end
    end

`endif

endmodule

// File: rtl/seq_alu_exec.sv
// Execute-stage ALU with valid/ready handshakes on both sides; shifts go through alu_shift_unit.
// Build option: ALU_BARREL_SHIFT_EN selects a single-cycle barrel shifter.
module seq_alu_exec
    import alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      alu_ctrl,
    input  logic [XLEN-1:0] src_a,
    input  logic [XLEN-1:0] src_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic            busy
);

    localparam int SHAMT_W = $clog2(XLEN);

    state_e          state_r;
    state_e          state_nxt_s;
    logic            accept_s;
    logic            shift_op_s;
    logic            sh_start_s;
    logic            sh_done_s;
    logic [XLEN-1:0] sh_res_s;
    logic [XLEN-1:0] simple_res_s;
    logic            load_s;
    logic [XLEN-1:0] load_val_s;
    logic            in_ready_nxt_s;
    logic            out_valid_nxt_s;
    logic            busy_nxt_s;

    assign accept_s   = in_valid && in_ready;
    assign shift_op_s = is_shift(alu_ctrl);
    assign sh_start_s = accept_s && shift_op_s;

    alu_shift_unit #(.XLEN(XLEN)) u_shift (
        .clk   (clk),
        .reset (reset),
        .start (sh_start_s),
        .op    (alu_ctrl),
        .a     (src_a),
        .shamt (src_b[SHAMT_W-1:0]),
        .done  (sh_done_s),
        .res   (sh_res_s)
    );

    // State register plus the handshake/status outputs, registered from the next state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            in_ready  <= in_ready_nxt_s;
            out_valid <= out_valid_nxt_s;
            busy      <= busy_nxt_s;
        end
    end

    // Next-state logic; a zero-length shift skips SHIFT entirely.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    if (shift_op_s && !sh_done_s) begin
                        state_nxt_s = SHIFT;
                    end else begin
                        state_nxt_s = DONE;
                    end
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            SHIFT: begin
                if (sh_done_s) begin
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = SHIFT;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = DONE;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // Moore outputs decoded from the next state so they come out of flops.
    always_comb begin
        in_ready_nxt_s  = 1'b0;
        out_valid_nxt_s = 1'b0;
        busy_nxt_s      = 1'b0;
        case (state_nxt_s)
            IDLE:    in_ready_nxt_s = 1'b1;
            SHIFT:   busy_nxt_s = 1'b1;
            DONE: begin
                out_valid_nxt_s = 1'b1;
                busy_nxt_s      = 1'b1;
            end
            default: in_ready_nxt_s = 1'b0;
        endcase
    end

    // Single-cycle ops; reserved codes and shift codes fall to zero here.
    always_comb begin
        simple_res_s = {XLEN{1'b0}};
        case (alu_ctrl)
            ALU_ADD:  simple_res_s = src_a + src_b;
            ALU_SUB:  simple_res_s = src_a - src_b;
            ALU_AND:  simple_res_s = src_a & src_b;
            ALU_OR:   simple_res_s = src_a | src_b;
            ALU_XOR:  simple_res_s = src_a ^ src_b;
            ALU_SLT:  simple_res_s = {{(XLEN-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
            ALU_SLTU: simple_res_s = {{(XLEN-1){1'b0}}, (src_a < src_b)};
            default:  simple_res_s = {XLEN{1'b0}};
        endcase
    end

    // The result register loads exactly once per op, then holds through backpressure.
    always_comb begin
        load_s     = 1'b0;
        load_val_s = simple_res_s;
        if (state_r == IDLE && accept_s && !shift_op_s) begin
            load_s     = 1'b1;
            load_val_s = simple_res_s;
        end else if ((state_r == IDLE && sh_start_s && sh_done_s) || (state_r == SHIFT && sh_done_s)) begin
            load_s     = 1'b1;
            load_val_s = sh_res_s;
        end else begin
            load_s     = 1'b0;
            load_val_s = simple_res_s;
        end
    end

    // Result and branch-compare flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            result <= {XLEN{1'b0}};
            zero   <= 1'b1;
        end else if (load_s) begin
            result <= load_val_s;
            zero   <= (load_val_s == {XLEN{1'b0}});
        end else begin
            result <= result;
            zero   <= zero;
        end
    end

endmodule

// File: tb/tb_seq_alu_exec.sv
// Randomized self-checking bench for seq_alu_exec against a plain-arithmetic reference model.
// Honours ALU_BARREL_SHIFT_EN for expected shift latency.
module tb_seq_alu_exec;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  alu_ctrl;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        zero;
    logic        busy;

    int checks = 0;
    int failures = 0;

    seq_alu_exec #(.XLEN(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .alu_ctrl  (alu_ctrl),
        .src_a     (src_a),
        .src_b     (src_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        int unsigned sh;
        logic signed [31:0] sa;
        sh = b % 32;
        sa = a;
        case (op)
            4'd0: return a + b;
            4'd1: return a - b;
            4'd2: return a & b;
            4'd3: return a | b;
            4'd4: return a ^ b;
            4'd5: return (sa < $signed(b)) ? 32'd1 : 32'd0;
            4'd6: return (a < b) ? 32'd1 : 32'd0;
            4'd7: return a << sh;
            4'd8: return a >> sh;
            4'd9: return sa >>> sh;
            default: return 32'd0;
        endcase
    endfunction

    function automatic int exp_lat(input logic [3:0] op, input logic [31:0] b);
`ifdef ALU_BARREL_SHIFT_EN
        return 1;
`else
        if (op >= 4'd7 && op <= 4'd9) return int'(b % 32) + 1;
        else return 1;
`endif
    endfunction

    // Issue one op, wait (bounded) for out_valid, capture outputs, then consume it.
    task automatic do_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] res, output logic z, output int lat);
        @(negedge clk);
        in_valid = 1'b1; alu_ctrl = op; src_a = a; src_b = b;
        @(posedge clk); #1;
        in_valid = 1'b0; alu_ctrl = 4'($urandom); src_a = $urandom; src_b = $urandom;
        lat = 1;
        while (!out_valid && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        res = result; z = zero;
        @(negedge clk); out_ready = 1'b1;
        @(posedge clk); #1; out_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b1; alu_ctrl = 4'd0; src_a = 32'd5; src_b = 32'd6; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk); reset = 1'b0; in_valid = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
            failures++; $display("FAIL reset_hs got in_ready=%b out_valid=%b busy=%b want 1 0 0", in_ready, out_valid, busy);
        end
        checks++; if (result !== 32'd0 || zero !== 1'b1) begin
            failures++; $display("FAIL reset_res got result=%h zero=%b want 0 1", result, zero);
        end
    endtask

    task automatic test_arith();
        logic [31:0] r; logic z; int lat;
        do_op(4'd0, 32'h7FFF_FFFF, 32'h1, r, z, lat);
        checks++; if (r !== 32'h8000_0000 || z !== 1'b0 || lat !== 1) begin
            failures++; $display("FAIL add_wrap got %h z=%b lat=%0d want 80000000 0 1", r, z, lat);
        end
        do_op(4'd1, 32'd5, 32'd5, r, z, lat);
        checks++; if (r !== 32'd0 || z !== 1'b1) begin
            failures++; $display("FAIL sub_zero got %h z=%b want 0 1", r, z);
        end
        do_op(4'd5, 32'hFFFF_FFFF, 32'h1, r, z, lat);
        checks++; if (r !== 32'd1) begin
            failures++; $display("FAIL slt got %h want 1", r);
        end
        do_op(4'd6, 32'hFFFF_FFFF, 32'h1, r, z, lat);
        checks++; if (r !== 32'd0 || z !== 1'b1) begin
            failures++; $display("FAIL sltu got %h z=%b want 0 1", r, z);
        end
    endtask

    task automatic test_shift();
        logic [31:0] r; logic z; int lat;
        do_op(4'd9, 32'h8000_0000, 32'd4, r, z, lat);
        checks++; if (r !== 32'hF800_0000 || lat !== exp_lat(4'd9, 32'd4)) begin
            failures++; $display("FAIL sra got %h lat=%0d want f8000000 lat=%0d", r, lat, exp_lat(4'd9, 32'd4));
        end
        do_op(4'd8, 32'h8000_0000, 32'd4, r, z, lat);
        checks++; if (r !== 32'h0800_0000) begin
            failures++; $display("FAIL srl got %h want 08000000", r);
        end
        do_op(4'd7, 32'h1, 32'h3F, r, z, lat);
        checks++; if (r !== 32'h8000_0000 || lat !== exp_lat(4'd7, 32'h3F)) begin
            failures++; $display("FAIL sll31 got %h lat=%0d want 80000000 lat=%0d", r, lat, exp_lat(4'd7, 32'h3F));
        end
        do_op(4'd7, 32'hDEAD_BEEF, 32'h20, r, z, lat);
        checks++; if (r !== 32'hDEAD_BEEF || lat !== 1) begin
            failures++; $display("FAIL sll0 got %h lat=%0d want deadbeef lat=1", r, lat);
        end
    endtask

    task automatic test_random();
        logic [31:0] r, a, b, exp; logic z; int lat; logic [3:0] op;
        for (int i = 0; i < 40; i++) begin
            op = 4'($urandom_range(0, 15));
            a = $urandom; b = $urandom;
            if (i % 4 == 0) a = 32'd0;
            if (i % 5 == 0) b = a;
            exp = model(op, a, b);
            do_op(op, a, b, r, z, lat);
            checks++; if (r !== exp || z !== (exp == 32'd0) || lat !== exp_lat(op, b)) begin
                failures++;
                $display("FAIL rand op=%0d a=%h b=%h got %h z=%b lat=%0d want %h z=%b lat=%0d",
                         op, a, b, r, z, lat, exp, (exp == 32'd0), exp_lat(op, b));
            end
        end
    endtask

    task automatic test_backpressure();
        int lat; logic [31:0] exp;
        exp = model(4'd4, 32'h1234_5678, 32'h0F0F_0F0F);
        @(negedge clk);
        in_valid = 1'b1; alu_ctrl = 4'd4; src_a = 32'h1234_5678; src_b = 32'h0F0F_0F0F;
        @(posedge clk); #1;
        alu_ctrl = 4'd0; src_a = 32'd0; src_b = 32'd0;
        lat = 1;
        while (!out_valid && lat < 200) begin @(posedge clk); #1; lat++; end
        for (int i = 0; i < 10; i++) begin
            checks++; if (out_valid !== 1'b1 || result !== exp || zero !== 1'b0 || in_ready !== 1'b0) begin
                failures++;
                $display("FAIL bp_hold cyc=%0d got v=%b r=%h z=%b rdy=%b want 1 %h 0 0", i, out_valid, result, zero, in_ready, exp);
            end
            @(posedge clk); #1;
        end
        @(negedge clk); out_ready = 1'b1; in_valid = 1'b0;
        @(posedge clk); #1; out_ready = 1'b0;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || result !== exp) begin
            failures++; $display("FAIL bp_release got v=%b rdy=%b r=%h want 0 1 %h", out_valid, in_ready, result, exp);
        end
    endtask

    task automatic test_reset_mid_shift();
        logic [31:0] r; logic z; int lat; int stray;
        @(negedge clk);
        in_valid = 1'b1; alu_ctrl = 4'd7; src_a = 32'h3; src_b = 32'd20;
        @(posedge clk); #1; in_valid = 1'b0;
        checks++; if (busy !== 1'b1) begin
            failures++; $display("FAIL busy_after_accept got %b want 1", busy);
        end
        repeat (13) @(posedge clk);
        @(negedge clk); reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || result !== 32'd0 || zero !== 1'b1) begin
            failures++;
            $display("FAIL mid_reset got rdy=%b v=%b busy=%b r=%h z=%b want 1 0 0 0 1", in_ready, out_valid, busy, result, zero);
        end
        stray = 0;
        for (int i = 0; i < 25; i++) begin
            @(posedge clk); #1;
            if (out_valid) stray++;
        end
        checks++; if (stray !== 0) begin
            failures++; $display("FAIL discard got %0d stray out_valid cycles want 0", stray);
        end
        do_op(4'hC, 32'hFFFF_FFFF, 32'h1, r, z, lat);
        checks++; if (r !== 32'd0 || z !== 1'b1 || lat !== 1) begin
            failures++; $display("FAIL reserved got %h z=%b lat=%0d want 0 1 1", r, z, lat);
        end
    endtask

    initial begin
        in_valid = 1'b0; out_ready = 1'b0; alu_ctrl = 4'd0; src_a = 32'd0; src_b = 32'd0; reset = 1'b1;
        test_reset();
        test_arith();
        test_shift();
        test_backpressure();
        test_random();
        test_reset_mid_shift();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
